// File: rtl/uart_comm_if.sv
// uart_comm_if: bundles the receive, command and response signals of uart_comm.
//   slave  modport: uart_comm side (frame assembler / response sender)
//   master modport: surrounding logic (UART transceiver + command consumer)
// Signals:
//   rx_rdy/rx_data/clr_rx_rdy      : byte handoff from the UART receiver
//   cmd_rdy/cmd/data/clr_cmd_rdy   : assembled command to the consumer
//   send_resp/resp/resp_sent       : one-byte response request from the consumer
//   trmt/tx_data/tx_done           : byte handoff to the UART transmitter
interface uart_comm_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    output clr_rx_rdy, cmd_rdy, cmd, data, trmt, tx_data, resp_sent
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    input  clr_rx_rdy, cmd_rdy, cmd, data, trmt, tx_data, resp_sent
  );
endinterface

// File: rtl/uart_comm.sv
// uart_comm: assembles three received bytes (opcode, data high, data low) into
// a command held with cmd_rdy until cleared, and sends a one-byte response
// through the UART transmitter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_comm_if.slave (see interface for signal list)
// Optional feature: define UART_COMM_FRAME_TMO_EN to enable an inter-byte
// timeout (parameter TMO_CYCLES, 2..65535) that abandons partial frames.
module uart_comm
`ifdef UART_COMM_FRAME_TMO_EN
#(
  parameter int unsigned TMO_CYCLES = 50000
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  uart_comm_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HI, LO} state_e;

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        tx_busy_q, tx_busy_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        trmt_q, trmt_d;
  logic        resp_sent_q, resp_sent_d;
`ifdef UART_COMM_FRAME_TMO_EN
  logic [15:0] gap_q, gap_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      hi_q        <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      cmd_rdy_q   <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
`ifdef UART_COMM_FRAME_TMO_EN
      gap_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      hi_q        <= hi_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cmd_rdy_q   <= cmd_rdy_d;
      tx_busy_q   <= tx_busy_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      resp_sent_q <= resp_sent_d;
`ifdef UART_COMM_FRAME_TMO_EN
      gap_q       <= gap_d;
`endif
    end
  end

  // Receive path: clear first so a completing frame in the same cycle wins.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hi_d      = hi_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    cmd_rdy_d = cmd_rdy_q;
    if (bus.clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (bus.rx_rdy) begin
      unique case (state_q)
        IDLE: begin
          op_d    = bus.rx_data;
          state_d = HI;
        end
        HI: begin
          hi_d    = bus.rx_data;
          state_d = LO;
        end
        LO: begin
          cmd_d     = op_q;
          data_d    = {hi_q, bus.rx_data};
          cmd_rdy_d = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef UART_COMM_FRAME_TMO_EN
    // An arriving byte takes precedence over expiry in the same cycle.
    gap_d = gap_q;
    if (bus.rx_rdy || state_q == IDLE) begin
      gap_d = '0;
    end else if (gap_q == 16'(TMO_CYCLES - 1)) begin
      gap_d   = '0;
      state_d = IDLE;
    end else begin
      gap_d = gap_q + 16'd1;
    end
`endif
  end

  // Transmit path: a request while busy is dropped; done while idle is ignored.
  always_comb begin
    tx_busy_d   = tx_busy_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    if (!tx_busy_q) begin
      if (bus.send_resp) begin
        tx_data_d = bus.resp;
        trmt_d    = 1'b1;
        tx_busy_d = 1'b1;
      end
    end else if (bus.tx_done) begin
      tx_busy_d   = 1'b0;
      resp_sent_d = 1'b1;
    end
  end

  assign bus.clr_rx_rdy = bus.rx_rdy;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.cmd        = cmd_q;
  assign bus.data       = data_q;
  assign bus.trmt       = trmt_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.resp_sent  = resp_sent_q;

endmodule

// File: tb/tb_uart_comm.sv
// tb_uart_comm: self-checking bench for uart_comm. Expected command state comes
// from a byte-queue frame model; expected response behaviour from a busy flag.
module tb_uart_comm;
  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fail;

  uart_comm_if u_if ();

`ifdef UART_COMM_FRAME_TMO_EN
  uart_comm #(.TMO_CYCLES(64)) dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
`else
  uart_comm dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame model
  logic [7:0]  frame_q[$];
  logic [7:0]  e_cmd;
  logic [15:0] e_data;
  logic        e_rdy;
  logic [7:0]  e_tx;

  function automatic void model_reset();
    frame_q.delete();
    e_cmd  = 8'h00;
    e_data = 16'h0000;
    e_rdy  = 1'b0;
    e_tx   = 8'h00;
  endfunction

  function automatic void model_rx(input logic [7:0] b, input logic clr);
    frame_q.push_back(b);
    if (clr) e_rdy = 1'b0;
    if (frame_q.size() == 3) begin
      e_cmd  = frame_q[0];
      e_data = {frame_q[1], frame_q[2]};
      e_rdy  = 1'b1;
      frame_q.delete();
    end
  endfunction

  // Presents one byte for one clock (optionally with clr_cmd_rdy); returns
  // clr_rx_rdy as seen mid-cycle.
  task automatic send_byte(input logic [7:0] b, input logic clr, output logic ack);
    @(negedge clk);
    u_if.rx_rdy      = 1'b1;
    u_if.rx_data     = b;
    u_if.clr_cmd_rdy = clr;
    #1 ack = u_if.clr_rx_rdy;
    @(posedge clk);
    #1;
    u_if.rx_rdy      = 1'b0;
    u_if.clr_cmd_rdy = 1'b0;
    model_rx(b, clr);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    u_if.clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 u_if.clr_cmd_rdy = 1'b0;
    e_rdy = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    u_if.rx_rdy = 0; u_if.rx_data = 0; u_if.clr_cmd_rdy = 0;
    u_if.send_resp = 0; u_if.resp = 0; u_if.tx_done = 0;
    rst_n = 1'b0;
    model_reset();
    idle(3);
    n_checks++;
    if ({u_if.cmd_rdy, u_if.cmd, u_if.data, u_if.trmt, u_if.tx_data, u_if.resp_sent, u_if.clr_rx_rdy}
        !== {1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b cmd=%h data=%h trmt=%b tx=%h rs=%b clr=%b, expected all zero",
               u_if.cmd_rdy, u_if.cmd, u_if.data, u_if.trmt, u_if.tx_data, u_if.resp_sent, u_if.clr_rx_rdy);
    end
    @(negedge clk) rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_frame();
    logic [7:0] bytes [3];
    logic ack;
    int unsigned acks;
    bytes[0] = 8'h02; bytes[1] = 8'h12; bytes[2] = 8'h34;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], 1'b0, ack);
      if (ack === 1'b1) acks++;
      n_checks++;
      if (u_if.clr_rx_rdy !== 1'b0) begin
        n_fail++; $display("FAIL basic_clr_rx_low: got %b expected 0", u_if.clr_rx_rdy);
      end
      if (i < 2) begin
        n_checks++;
        if (u_if.cmd_rdy !== 1'b0 || u_if.cmd !== 8'h00 || u_if.data !== 16'h0000) begin
          n_fail++;
          $display("FAIL basic_partial: got rdy=%b cmd=%h data=%h expected 0/00/0000",
                   u_if.cmd_rdy, u_if.cmd, u_if.data);
        end
      end
    end
    n_checks++;
    if (acks != 3) begin
      n_fail++; $display("FAIL basic_clr_rx_pulses: got %0d expected 3", acks);
    end
    n_checks++;
    if (u_if.cmd_rdy !== 1'b1 || u_if.cmd !== 8'h02 || u_if.data !== 16'h1234) begin
      n_fail++;
      $display("FAIL basic_frame: got rdy=%b cmd=%h data=%h expected 1/02/1234",
               u_if.cmd_rdy, u_if.cmd, u_if.data);
    end
    idle(2);
    n_checks++;
    if (u_if.cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL basic_rdy_held: got %b expected 1", u_if.cmd_rdy);
    end
    pulse_clr();
    n_checks++;
    if (u_if.cmd_rdy !== 1'b0 || u_if.cmd !== 8'h02 || u_if.data !== 16'h1234) begin
      n_fail++;
      $display("FAIL basic_clear: got rdy=%b cmd=%h data=%h expected 0/02/1234",
               u_if.cmd_rdy, u_if.cmd, u_if.data);
    end
  endtask

  task automatic test_overwrite();
    logic [7:0] bytes [6];
    logic ack;
    bytes[0] = 8'h05; bytes[1] = 8'h00; bytes[2] = 8'hFF;
    bytes[3] = 8'h03; bytes[4] = 8'h80; bytes[5] = 8'h01;
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes[i], 1'b0, ack);
      if (i == 4) begin
        n_checks++;
        if (u_if.cmd_rdy !== 1'b1 || u_if.cmd !== 8'h05 || u_if.data !== 16'h00FF) begin
          n_fail++;
          $display("FAIL overwrite_partial_keeps: got rdy=%b cmd=%h data=%h expected 1/05/00ff",
                   u_if.cmd_rdy, u_if.cmd, u_if.data);
        end
      end
    end
    n_checks++;
    if (u_if.cmd_rdy !== 1'b1 || u_if.cmd !== 8'h03 || u_if.data !== 16'h8001) begin
      n_fail++;
      $display("FAIL overwrite_final: got rdy=%b cmd=%h data=%h expected 1/03/8001",
               u_if.cmd_rdy, u_if.cmd, u_if.data);
    end
    pulse_clr();
  endtask

  task automatic test_clr_collision();
    logic ack;
    send_byte(8'h04, 1'b0, ack);
    send_byte(8'hAB, 1'b0, ack);
    send_byte(8'hCD, 1'b1, ack);
    n_checks++;
    if (u_if.cmd_rdy !== 1'b1 || u_if.cmd !== 8'h04 || u_if.data !== 16'hABCD) begin
      n_fail++;
      $display("FAIL clr_collision: got rdy=%b cmd=%h data=%h expected 1/04/abcd",
               u_if.cmd_rdy, u_if.cmd, u_if.data);
    end
    pulse_clr();
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [7:0] b;
    logic clr;
    for (int i = 0; i < 36; i++) begin
      b   = 8'($urandom);
      clr = ($urandom_range(3) == 0);
      send_byte(b, clr, ack);
      n_checks++;
      if (ack !== 1'b1 || u_if.cmd_rdy !== e_rdy || u_if.cmd !== e_cmd || u_if.data !== e_data) begin
        n_fail++;
        $display("FAIL random_frames[%0d]: got ack=%b rdy=%b cmd=%h data=%h expected 1/%b/%h/%h",
                 i, ack, u_if.cmd_rdy, u_if.cmd, u_if.data, e_rdy, e_cmd, e_data);
      end
      if ($urandom_range(4) == 0) pulse_clr();
      idle($urandom_range(2));
    end
  endtask

  task automatic test_response();
    @(negedge clk); u_if.send_resp = 1'b1; u_if.resp = 8'hA5;
    @(posedge clk); #1 u_if.send_resp = 1'b0; u_if.resp = 8'h00;
    n_checks++;
    if (u_if.trmt !== 1'b1 || u_if.tx_data !== 8'hA5) begin
      n_fail++; $display("FAIL resp_start: got trmt=%b tx=%h expected 1/a5", u_if.trmt, u_if.tx_data);
    end
    idle(1);
    n_checks++;
    if (u_if.trmt !== 1'b0) begin
      n_fail++; $display("FAIL resp_trmt_pulse: got %b expected 0", u_if.trmt);
    end
    @(negedge clk); u_if.send_resp = 1'b1; u_if.resp = 8'h5A;
    @(posedge clk); #1 u_if.send_resp = 1'b0;
    n_checks++;
    if (u_if.trmt !== 1'b0 || u_if.tx_data !== 8'hA5) begin
      n_fail++; $display("FAIL resp_busy_drop: got trmt=%b tx=%h expected 0/a5", u_if.trmt, u_if.tx_data);
    end
    @(negedge clk); u_if.tx_done = 1'b1;
    @(posedge clk); #1 u_if.tx_done = 1'b0;
    n_checks++;
    if (u_if.resp_sent !== 1'b1 || u_if.tx_data !== 8'hA5) begin
      n_fail++; $display("FAIL resp_sent: got rs=%b tx=%h expected 1/a5", u_if.resp_sent, u_if.tx_data);
    end
    idle(1);
    n_checks++;
    if (u_if.resp_sent !== 1'b0) begin
      n_fail++; $display("FAIL resp_sent_pulse: got %b expected 0", u_if.resp_sent);
    end
    // tx_done while idle must not produce resp_sent
    @(negedge clk); u_if.tx_done = 1'b1;
    @(posedge clk); #1 u_if.tx_done = 1'b0;
    n_checks++;
    if (u_if.resp_sent !== 1'b0) begin
      n_fail++; $display("FAIL resp_spurious_done: got %b expected 0", u_if.resp_sent);
    end
    e_tx = 8'hA5;
  endtask

  // Random responses interleaved with received bytes on the same cycles.
  task automatic test_random_resp();
    logic [7:0] r;
    logic [7:0] rb;
    logic busy;
    busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r  = 8'($urandom);
      rb = 8'($urandom);
      u_if.send_resp = ($urandom_range(2) == 0);
      u_if.resp      = r;
      u_if.tx_done   = ($urandom_range(2) == 0);
      u_if.rx_rdy    = ($urandom_range(1) == 0);
      u_if.rx_data   = rb;
      @(posedge clk); #1;
      n_checks++;
      if (u_if.trmt !== (u_if.send_resp && !busy) ||
          u_if.resp_sent !== (u_if.tx_done && busy) ||
          u_if.tx_data !== ((u_if.send_resp && !busy) ? r : e_tx)) begin
        n_fail++;
        $display("FAIL random_resp[%0d]: got trmt=%b rs=%b tx=%h expected %b/%b/%h", i,
                 u_if.trmt, u_if.resp_sent, u_if.tx_data,
                 u_if.send_resp && !busy, u_if.tx_done && busy,
                 (u_if.send_resp && !busy) ? r : e_tx);
      end
      if (u_if.rx_rdy) model_rx(rb, 1'b0);
      if (!busy && u_if.send_resp) begin busy = 1'b1; e_tx = r; end
      else if (busy && u_if.tx_done) busy = 1'b0;
      u_if.send_resp = 0; u_if.tx_done = 0; u_if.rx_rdy = 0;
      n_checks++;
      if (u_if.cmd_rdy !== e_rdy || u_if.cmd !== e_cmd || u_if.data !== e_data) begin
        n_fail++;
        $display("FAIL random_resp_rx[%0d]: got rdy=%b cmd=%h data=%h expected %b/%h/%h",
                 i, u_if.cmd_rdy, u_if.cmd, u_if.data, e_rdy, e_cmd, e_data);
      end
    end
    // Leave the transmitter idle
    if (busy) begin
      @(negedge clk); u_if.tx_done = 1'b1;
      @(posedge clk); #1 u_if.tx_done = 1'b0;
    end
  endtask

`ifdef UART_COMM_FRAME_TMO_EN
  task automatic test_timeout();
    logic ack;
    // Realign to a frame boundary and clear pending state
    while (frame_q.size() != 0) send_byte(8'h00, 1'b0, ack);
    pulse_clr();
    send_byte(8'h06, 1'b0, ack);
    idle(100);
    frame_q.delete();
    send_byte(8'h07, 1'b0, ack);
    send_byte(8'h00, 1'b0, ack);
    n_checks++;
    if (u_if.cmd_rdy !== 1'b0) begin
      n_fail++; $display("FAIL tmo_discard: got rdy=%b expected 0", u_if.cmd_rdy);
    end
    send_byte(8'h00, 1'b0, ack);
    n_checks++;
    if (u_if.cmd_rdy !== 1'b1 || u_if.cmd !== 8'h07 || u_if.data !== 16'h0000) begin
      n_fail++;
      $display("FAIL tmo_frame: got rdy=%b cmd=%h data=%h expected 1/07/0000",
               u_if.cmd_rdy, u_if.cmd, u_if.data);
    end
    pulse_clr();
    // Byte on the expiry cycle (63 idle edges) is still accepted
    send_byte(8'h09, 1'b0, ack);
    idle(63);
    send_byte(8'h11, 1'b0, ack);
    idle(63);
    send_byte(8'h22, 1'b0, ack);
    n_checks++;
    if (u_if.cmd_rdy !== 1'b1 || u_if.cmd !== 8'h09 || u_if.data !== 16'h1122) begin
      n_fail++;
      $display("FAIL tmo_edge_accept: got rdy=%b cmd=%h data=%h expected 1/09/1122",
               u_if.cmd_rdy, u_if.cmd, u_if.data);
    end
    pulse_clr();
  endtask
`endif

  task automatic test_reset_midframe();
    logic ack;
    @(negedge clk); u_if.send_resp = 1'b1; u_if.resp = 8'h3C;
    @(posedge clk); #1 u_if.send_resp = 1'b0;
    send_byte(8'h55, 1'b0, ack);
    send_byte(8'h66, 1'b0, ack);
    @(negedge clk) rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({u_if.cmd_rdy, u_if.cmd, u_if.data, u_if.trmt, u_if.tx_data, u_if.resp_sent}
        !== {1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL midframe_reset: got rdy=%b cmd=%h data=%h trmt=%b tx=%h rs=%b expected all zero",
               u_if.cmd_rdy, u_if.cmd, u_if.data, u_if.trmt, u_if.tx_data, u_if.resp_sent);
    end
    idle(2);
    @(negedge clk) rst_n = 1'b1;
    // Busy flag cleared by reset: a new request is accepted
    @(negedge clk); u_if.send_resp = 1'b1; u_if.resp = 8'hC3;
    @(posedge clk); #1 u_if.send_resp = 1'b0;
    n_checks++;
    if (u_if.trmt !== 1'b1 || u_if.tx_data !== 8'hC3) begin
      n_fail++; $display("FAIL midframe_tx_free: got trmt=%b tx=%h expected 1/c3", u_if.trmt, u_if.tx_data);
    end
    send_byte(8'h08, 1'b0, ack);
    send_byte(8'h00, 1'b0, ack);
    send_byte(8'h00, 1'b0, ack);
    n_checks++;
    if (u_if.cmd_rdy !== 1'b1 || u_if.cmd !== 8'h08 || u_if.data !== 16'h0000) begin
      n_fail++;
      $display("FAIL midframe_new_frame: got rdy=%b cmd=%h data=%h expected 1/08/0000",
               u_if.cmd_rdy, u_if.cmd, u_if.data);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_frame();
    test_overwrite();
    test_clr_collision();
    test_back_to_back();
    test_response();
    test_random_resp();
`ifdef UART_COMM_FRAME_TMO_EN
    test_timeout();
`endif
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
